// File: rtl/opram_pkg.sv
// rtl/opram_pkg.sv - shared types and constants for the opcode RAM loader
package opram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } opram_state_e;

    localparam logic [7:0] DEF_RESET_OP = 8'h00;

    function automatic int opram_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/opram_mem.sv
// rtl/opram_mem.sv - simple dual-port RAM, one write port, one registered read port
module opram_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [1 << ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/opram_loader.sv
// rtl/opram_loader.sv - opcode RAM with streamed program load and registered fetch
module opram_loader
    import opram_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] RESET_OP = DEF_RESET_OP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   op_count,
    output logic              busy,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] op,
    output logic              op_valid
);

    localparam int            DEPTH    = opram_depth(ADDR_W);
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    opram_state_e      state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              oor_q, oor_d;

    logic              beat_ok, fetch_ok, in_range;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // oor_q resets high so op shows RESET_OP before the uninitialised RAM is ever read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            oor_q   <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            oor_q   <= oor_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        done_d   = 1'b0;
        valid_d  = 1'b0;
        oor_d    = oor_q;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        in_range = 1'b0;
        beat_ok  = (state_q == LOAD) && load_valid && !load_start;
        fetch_ok = (state_q == RUN) && fetch_en && !load_start;

        if (load_start) begin
            state_d = LOAD;
            wptr_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (beat_ok) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (load_last || (cnt_q == LAST_CNT)) begin
                state_d = RUN;
                done_d  = 1'b1;
                err_d   = !load_last;
            end
        end

        if (fetch_ok) begin
            in_range = ({1'b0, fetch_addr} < cnt_q);
            valid_d  = 1'b1;
            mem_re   = in_range;
            oor_d    = !in_range;
        end
    end

    opram_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wptr_q),
        .wdata(load_data),
        .re   (mem_re),
        .raddr(fetch_addr),
        .rdata(mem_rdata)
    );

    assign load_ready = (state_q == LOAD);
    assign busy       = (state_q == LOAD);
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign op_count   = cnt_q;
    assign op_valid   = valid_q;
    assign op         = oor_q ? RESET_OP : mem_rdata;

endmodule

// File: tb/tb_opram_loader.sv
// tb/tb_opram_loader.sv - directed self-checking bench for opram_loader
module tb_opram_loader;

    logic       clk;
    logic       rst;
    logic       load_start, load_valid, load_last;
    logic [7:0] load_data;
    logic       load_ready, load_done, load_err, busy;
    logic [4:0] op_count;
    logic       fetch_en;
    logic [3:0] fetch_addr;
    logic [7:0] op;
    logic       op_valid;

    int n_checks = 0;
    int n_errors = 0;

    opram_loader dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_ready(load_ready),
        .load_done (load_done),
        .load_err  (load_err),
        .op_count  (op_count),
        .busy      (busy),
        .fetch_en  (fetch_en),
        .fetch_addr(fetch_addr),
        .op        (op),
        .op_valid  (op_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [3:0] a, input logic [7:0] exp);
        fetch_en   = 1'b1;
        fetch_addr = a;
        tick();
        fetch_en   = 1'b0;
        check({tag, "_valid"}, op_valid, 1);
        check({tag, "_op"}, op, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op"}, op, 8'h00);
        check({tag, "_op_valid"}, op_valid, 0);
        check({tag, "_done"}, load_done, 0);
        check({tag, "_err"}, load_err, 0);
        check({tag, "_count"}, op_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, load_ready, 0);
    endtask

    initial begin
        rst        = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 8'h00;
        fetch_en   = 1'b0;
        fetch_addr = 4'h0;
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b1;

        // fetch in IDLE is ignored
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("idle_fetch_valid", op_valid, 0);
        check("idle_fetch_op", op, 8'h00);

        // three-beat program
        start_load();
        check("ld3_ready", load_ready, 1);
        check("ld3_busy", busy, 1);
        beat(8'hA1, 1'b0);
        beat(8'hB2, 1'b0);
        check("ld3_mid_count", op_count, 2);
        check("ld3_mid_done", load_done, 0);
        beat(8'hC3, 1'b1);
        check("ld3_done", load_done, 1);
        check("ld3_count", op_count, 3);
        check("ld3_err", load_err, 0);
        check("ld3_busy_after", busy, 0);
        tick();
        check("ld3_done_pulse", load_done, 0);
        fetch("f0", 4'd0, 8'hA1);
        fetch("f1", 4'd1, 8'hB2);
        fetch("f2", 4'd2, 8'hC3);
        fetch("f5_oor", 4'd5, 8'h00);
        fetch("f3_oor", 4'd3, 8'h00);
        fetch("f1_again", 4'd1, 8'hB2);
        tick();
        check("hold_valid", op_valid, 0);
        check("hold_op", op, 8'hB2);

        // sixteen beats, no load_last: truncated
        start_load();
        check("ld16_start_count", op_count, 0);
        for (int i = 0; i < 16; i++) beat(8'h10 + 8'(i), 1'b0);
        check("ld16_done", load_done, 1);
        check("ld16_count", op_count, 16);
        check("ld16_err", load_err, 1);
        check("ld16_busy", busy, 0);
        fetch("ld16_f15", 4'd15, 8'h1F);
        fetch("ld16_f0", 4'd0, 8'h10);
        check("ld16_err_sticky", load_err, 1);

        // sixteen beats, load_last on the last one: clean
        start_load();
        check("ld16l_err_cleared", load_err, 0);
        for (int i = 0; i < 16; i++) beat(8'h20 + 8'(i), i == 15);
        check("ld16l_done", load_done, 1);
        check("ld16l_count", op_count, 16);
        check("ld16l_err", load_err, 0);
        fetch("ld16l_f7", 4'd7, 8'h27);

        // load_start with fetch_en in RUN: fetch dropped
        fetch_en   = 1'b1;
        fetch_addr = 4'd7;
        start_load();
        fetch_en = 1'b0;
        check("start_fetch_valid", op_valid, 0);
        check("start_fetch_busy", busy, 1);
        beat(8'h11, 1'b0);
        // fetch during LOAD ignored, op holds
        fetch_en = 1'b1;
        fetch_addr = 4'd0;
        beat(8'h22, 1'b0);
        fetch_en = 1'b0;
        check("load_fetch_valid", op_valid, 0);
        check("load_fetch_op", op, 8'h27);
        check("restart_pre_count", op_count, 2);
        load_start = 1'b1;
        beat(8'h7F, 1'b0);
        load_start = 1'b0;
        check("restart_count", op_count, 0);
        check("restart_busy", busy, 1);
        beat(8'h55, 1'b1);
        check("ld1_count", op_count, 1);
        check("ld1_done", load_done, 1);
        fetch("ld1_f0", 4'd0, 8'h55);
        fetch("ld1_f1_oor", 4'd1, 8'h00);
        fetch("ld1_f0b", 4'd0, 8'h55);

        // async reset during a fetch
        fetch_en   = 1'b1;
        fetch_addr = 4'd0;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("rst_fetch");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_fetch_valid", op_valid, 0);
        fetch_en = 1'b0;

        // async reset during a load
        start_load();
        beat(8'h66, 1'b0);
        check("rst_load_pre_count", op_count, 1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("rst_load");
        @(negedge clk);
        rst = 1'b1;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        check("post_rst_load_count", op_count, 0);
        check("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
